// File: rtl/multicycle_ctrl.sv
// Multicycle LEGv8 control FSM: fetch/decode/execute/memory/writeback sequencing.
// Optional CBNZ support is compiled in when CBNZ_EN is defined.
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [10:0]      op,
  input  logic             instr_valid,
  input  logic             dmem_ready,
  input  logic             zero,
  output logic             irwrite,
  output logic             pcwrite,
  output logic             pcsrc,
  output logic             reg2loc,
  output logic             alusrc,
  output logic [1:0]       aluop,
  output logic             regwrite,
  output logic             memtoreg,
  output logic             memread,
  output logic             memwrite,
  output logic             error,
  output logic [CNT_W-1:0] retired
);

  // Wait counter only needs to hold 0..MEM_TIMEOUT-1.
  localparam int unsigned TW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
`ifdef CBNZ_EN
  localparam logic [7:0]  OP_CBNZ = 8'b10110101;
`endif

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    EXEC_R = 4'd2,
    RWB    = 4'd3,
    MEMADR = 4'd4,
    MEMRD  = 4'd5,
    MEMWB  = 4'd6,
    MEMWR  = 4'd7,
    BRANCH = 4'd8,
    ERROR  = 4'd9
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tmo_q;
  logic            tmo_clr, tmo_inc, ret_inc;
  logic            is_r, is_ldur, is_stur, is_cbz, is_cbnz;
  logic            tmo_hit;

  // Opcode classification; op is stable from DECODE until the next FETCH.
  always_comb begin
    is_r    = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_ORR);
    is_ldur = (op == OP_LDUR);
    is_stur = (op == OP_STUR);
    is_cbz  = (op[10:3] == OP_CBZ);
`ifdef CBNZ_EN
    is_cbnz = (op[10:3] == OP_CBNZ);
`else
    is_cbnz = 1'b0;
`endif
    tmo_hit = (tmo_q == TW'(MEM_TIMEOUT - 1));
  end

  // Next-state and control decode; outputs depend on state and live inputs.
  always_comb begin
    state_d  = state_q;
    irwrite  = 1'b0;
    pcwrite  = 1'b0;
    pcsrc    = 1'b0;
    reg2loc  = 1'b0;
    alusrc   = 1'b0;
    aluop    = 2'b00;
    regwrite = 1'b0;
    memtoreg = 1'b0;
    memread  = 1'b0;
    memwrite = 1'b0;
    error    = 1'b0;
    tmo_clr  = 1'b0;
    tmo_inc  = 1'b0;
    ret_inc  = 1'b0;

    case (state_q)
      FETCH: begin
        if (instr_valid) begin
          irwrite = 1'b1;
          pcwrite = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        reg2loc = is_stur || is_cbz || is_cbnz;
        if (is_r)                      state_d = EXEC_R;
        else if (is_ldur || is_stur)   state_d = MEMADR;
        else if (is_cbz || is_cbnz)    state_d = BRANCH;
        else                           state_d = ERROR;
      end
      EXEC_R: begin
        aluop   = 2'b10;
        state_d = RWB;
      end
      RWB: begin
        aluop    = 2'b10;
        regwrite = 1'b1;
        ret_inc  = 1'b1;
        state_d  = FETCH;
      end
      MEMADR: begin
        alusrc  = 1'b1;
        reg2loc = is_stur;
        tmo_clr = 1'b1;
        if (is_ldur)      state_d = MEMRD;
        else if (is_stur) state_d = MEMWR;
        else              state_d = ERROR;
      end
      MEMRD: begin
        memread = 1'b1;
        alusrc  = 1'b1;
        if (dmem_ready)   state_d = MEMWB;
        else if (tmo_hit) state_d = ERROR;
        else              tmo_inc = 1'b1;
      end
      MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        ret_inc  = 1'b1;
        state_d  = FETCH;
      end
      MEMWR: begin
        memwrite = 1'b1;
        alusrc   = 1'b1;
        reg2loc  = 1'b1;
        if (dmem_ready) begin
          ret_inc = 1'b1;
          state_d = FETCH;
        end else if (tmo_hit) begin
          state_d = ERROR;
        end else begin
          tmo_inc = 1'b1;
        end
      end
      BRANCH: begin
        aluop   = 2'b01;
        reg2loc = 1'b1;
        pcsrc   = 1'b1;
        pcwrite = is_cbnz ? ~zero : zero;
        ret_inc = 1'b1;
        state_d = FETCH;
      end
      ERROR: begin
        error = 1'b1;
      end
      default: begin
        state_d = ERROR;
      end
    endcase
  end

  // State, memory wait counter and retired-instruction counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      tmo_q   <= '0;
      retired <= '0;
    end else begin
      state_q <= state_d;
      if (tmo_clr)      tmo_q <= '0;
      else if (tmo_inc) tmo_q <= tmo_q + TW'(1);
      if (ret_inc)      retired <= retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Table-driven cycle-by-cycle check of multicycle_ctrl (MEM_TIMEOUT=4, 3-bit retired counter).
// Expectations for op 10110101xxx follow CBNZ_EN.
module tb_multicycle_ctrl;

  localparam int unsigned CNT_W = 3;

  localparam logic [10:0] NOP  = 11'b00000000000;
  localparam logic [10:0] ADD  = 11'b10001011000;
  localparam logic [10:0] SUB  = 11'b11001011000;
  localparam logic [10:0] ANDI = 11'b10001010000;
  localparam logic [10:0] ORR  = 11'b10101010000;
  localparam logic [10:0] LDUR = 11'b11111000010;
  localparam logic [10:0] STUR = 11'b11111000000;
  localparam logic [10:0] CBZ  = 11'b10110100101;
  localparam logic [10:0] CBNZ = 11'b10110101000;
  localparam logic [10:0] BAD  = 11'b11111111111;

  // Fields: irwrite pcwrite pcsrc reg2loc alusrc aluop[1:0] regwrite memtoreg memread memwrite error
  localparam logic [11:0] E_NONE    = 12'b0_0_0_0_0_00_0_0_0_0_0;
  localparam logic [11:0] E_FETCH   = 12'b1_1_0_0_0_00_0_0_0_0_0;
  localparam logic [11:0] E_DEC     = 12'b0_0_0_0_0_00_0_0_0_0_0;
  localparam logic [11:0] E_DEC_R2  = 12'b0_0_0_1_0_00_0_0_0_0_0;
  localparam logic [11:0] E_EXR     = 12'b0_0_0_0_0_10_0_0_0_0_0;
  localparam logic [11:0] E_RWB     = 12'b0_0_0_0_0_10_1_0_0_0_0;
  localparam logic [11:0] E_MADR_LD = 12'b0_0_0_0_1_00_0_0_0_0_0;
  localparam logic [11:0] E_MADR_ST = 12'b0_0_0_1_1_00_0_0_0_0_0;
  localparam logic [11:0] E_MRD     = 12'b0_0_0_0_1_00_0_0_1_0_0;
  localparam logic [11:0] E_MWB     = 12'b0_0_0_0_0_00_1_1_0_0_0;
  localparam logic [11:0] E_MWR     = 12'b0_0_0_1_1_00_0_0_0_1_0;
  localparam logic [11:0] E_BR_T    = 12'b0_1_1_1_0_01_0_0_0_0_0;
  localparam logic [11:0] E_BR_N    = 12'b0_0_1_1_0_01_0_0_0_0_0;
  localparam logic [11:0] E_ERR     = 12'b0_0_0_0_0_00_0_0_0_0_1;

  typedef struct {
    logic [10:0]      op;
    logic             iv;
    logic             rdy;
    logic             z;
    logic [11:0]      exp;
    logic [CNT_W-1:0] ret;
    string            name;
  } vec_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [10:0]      op;
  logic             instr_valid, dmem_ready, zero;
  logic             irwrite, pcwrite, pcsrc, reg2loc, alusrc;
  logic [1:0]       aluop;
  logic             regwrite, memtoreg, memread, memwrite, error;
  logic [CNT_W-1:0] retired;
  logic [11:0]      outs;

  int errors = 0;
  int checks = 0;
  vec_t vecs[$];

  assign outs = {irwrite, pcwrite, pcsrc, reg2loc, alusrc, aluop,
                 regwrite, memtoreg, memread, memwrite, error};

  multicycle_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .op(op), .instr_valid(instr_valid),
    .dmem_ready(dmem_ready), .zero(zero), .irwrite(irwrite), .pcwrite(pcwrite),
    .pcsrc(pcsrc), .reg2loc(reg2loc), .alusrc(alusrc), .aluop(aluop),
    .regwrite(regwrite), .memtoreg(memtoreg), .memread(memread),
    .memwrite(memwrite), .error(error), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic add(input logic [10:0] o, input logic iv, input logic rdy, input logic z,
                     input logic [11:0] e, input logic [CNT_W-1:0] r, input string nm);
    vec_t v;
    v.op = o; v.iv = iv; v.rdy = rdy; v.z = z; v.exp = e; v.ret = r; v.name = nm;
    vecs.push_back(v);
  endtask

  task automatic chk_outs(input logic [11:0] e, input string nm);
    checks++;
    if (outs !== e) begin
      errors++;
      $display("FAIL %s: outputs=%b expected=%b", nm, outs, e);
    end
  endtask

  task automatic chk_ret(input logic [CNT_W-1:0] r, input string nm);
    checks++;
    if (retired !== r) begin
      errors++;
      $display("FAIL %s retired: got=%0d expected=%0d", nm, retired, r);
    end
  endtask

  // One cycle: drive inputs, sample mid-cycle, advance past the rising edge.
  task automatic step(input logic [10:0] o, input logic iv, input logic rdy, input logic z,
                      input logic [11:0] e, input logic [CNT_W-1:0] r, input string nm);
    op = o; instr_valid = iv; dmem_ready = rdy; zero = z;
    @(negedge clk);
    chk_outs(e, nm);
    chk_ret(r, nm);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(NOP, 1'b0, 1'b0, 1'b0, E_NONE, 0, "reset");
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; op = NOP; instr_valid = 1'b0; dmem_ready = 1'b0; zero = 1'b0;

    for (int i = 0; i < 5; i++) add(NOP, 0, 0, 0, E_NONE, 0, "idle");
    add(ADD, 1, 0, 0, E_FETCH, 0, "add_fetch");
    add(ADD, 0, 0, 0, E_DEC,   0, "add_decode");
    add(ADD, 0, 0, 0, E_EXR,   0, "add_exec");
    add(ADD, 0, 0, 0, E_RWB,   0, "add_wb");
    add(SUB, 1, 0, 0, E_FETCH, 1, "sub_fetch");
    add(SUB, 0, 0, 0, E_DEC,   1, "sub_decode");
    add(SUB, 0, 0, 0, E_EXR,   1, "sub_exec");
    add(SUB, 0, 0, 0, E_RWB,   1, "sub_wb");
    add(ANDI, 1, 0, 0, E_FETCH, 2, "and_fetch");
    add(ANDI, 0, 0, 0, E_DEC,   2, "and_decode");
    add(ANDI, 0, 0, 0, E_EXR,   2, "and_exec");
    add(ANDI, 0, 0, 0, E_RWB,   2, "and_wb");
    add(ORR, 1, 0, 0, E_FETCH, 3, "orr_fetch");
    add(ORR, 0, 0, 0, E_DEC,   3, "orr_decode");
    add(ORR, 0, 0, 0, E_EXR,   3, "orr_exec");
    add(ORR, 0, 0, 0, E_RWB,   3, "orr_wb");
    // LDUR with three wait states; ready arrives on the cycle the limit would hit.
    add(LDUR, 1, 0, 0, E_FETCH,   4, "ldur_fetch");
    add(LDUR, 0, 0, 0, E_DEC,     4, "ldur_decode");
    add(LDUR, 0, 0, 0, E_MADR_LD, 4, "ldur_memadr");
    add(LDUR, 0, 0, 0, E_MRD,     4, "ldur_wait0");
    add(LDUR, 0, 0, 0, E_MRD,     4, "ldur_wait1");
    add(LDUR, 0, 0, 0, E_MRD,     4, "ldur_wait2");
    add(LDUR, 0, 1, 0, E_MRD,     4, "ldur_ready");
    add(LDUR, 0, 0, 0, E_MWB,     4, "ldur_wb");
    add(STUR, 1, 0, 0, E_FETCH,   5, "stur_fetch");
    add(STUR, 0, 0, 0, E_DEC_R2,  5, "stur_decode");
    add(STUR, 0, 0, 0, E_MADR_ST, 5, "stur_memadr");
    add(STUR, 0, 1, 0, E_MWR,     5, "stur_ready");
    add(CBZ, 1, 0, 1, E_FETCH,  6, "cbz1_fetch");
    add(CBZ, 0, 0, 0, E_DEC_R2, 6, "cbz1_decode");
    add(CBZ, 0, 0, 1, E_BR_T,   6, "cbz1_branch");
    add(CBZ, 1, 0, 0, E_FETCH,  7, "cbz0_fetch");
    add(CBZ, 0, 0, 1, E_DEC_R2, 7, "cbz0_decode");
    add(CBZ, 0, 0, 0, E_BR_N,   7, "cbz0_branch");
    add(NOP, 0, 0, 0, E_NONE,   0, "retired_wrap");
    // STUR with no ready: four write cycles then sticky error, no retire.
    add(STUR, 1, 0, 0, E_FETCH,   0, "stto_fetch");
    add(STUR, 0, 0, 0, E_DEC_R2,  0, "stto_decode");
    add(STUR, 0, 0, 0, E_MADR_ST, 0, "stto_memadr");
    for (int i = 0; i < 4; i++) add(STUR, 0, 0, 0, E_MWR, 0, "stto_wait");
    add(STUR, 0, 0, 0, E_ERR, 0, "stto_error");
    add(ADD,  1, 1, 1, E_ERR, 0, "error_sticky");
    add(ADD,  1, 0, 0, E_ERR, 0, "error_sticky2");

    @(posedge clk);
    #1;
    step(NOP, 0, 0, 0, E_NONE, 0, "in_reset0");
    step(NOP, 0, 0, 0, E_NONE, 0, "in_reset1");
    reset = 1'b0;

    foreach (vecs[i]) step(vecs[i].op, vecs[i].iv, vecs[i].rdy, vecs[i].z,
                           vecs[i].exp, vecs[i].ret, vecs[i].name);

    do_reset();
    step(NOP, 0, 0, 0, E_NONE, 0, "error_cleared");

    // CBNZ opcode with zero=0
    step(CBNZ, 1, 0, 0, E_FETCH, 0, "cbnz_fetch");
`ifdef CBNZ_EN
    step(CBNZ, 0, 0, 0, E_DEC_R2, 0, "cbnz_decode");
    step(CBNZ, 0, 0, 0, E_BR_T,   0, "cbnz_branch");
    step(NOP,  0, 0, 0, E_NONE,   1, "cbnz_retired");
`else
    step(CBNZ, 0, 0, 0, E_DEC, 0, "cbnz_decode");
    step(CBNZ, 0, 0, 0, E_ERR, 0, "cbnz_illegal");
    step(NOP,  0, 0, 0, E_ERR, 0, "cbnz_sticky");
`endif

    do_reset();
    step(BAD, 1, 0, 0, E_FETCH, 0, "bad_fetch");
    step(BAD, 0, 0, 0, E_DEC,   0, "bad_decode");
    step(BAD, 0, 0, 0, E_ERR,   0, "bad_error");

    // Reset during a pending read drops memread at once and clears retired.
    do_reset();
    step(CBZ,  1, 0, 1, E_FETCH,   0, "pre_fetch");
    step(CBZ,  0, 0, 1, E_DEC_R2,  0, "pre_decode");
    step(CBZ,  0, 0, 1, E_BR_T,    0, "pre_branch");
    step(LDUR, 1, 0, 0, E_FETCH,   1, "rst_ld_fetch");
    step(LDUR, 0, 0, 0, E_DEC,     1, "rst_ld_decode");
    step(LDUR, 0, 0, 0, E_MADR_LD, 1, "rst_ld_memadr");
    step(LDUR, 0, 0, 0, E_MRD,     1, "rst_ld_wait");
    dmem_ready = 1'b0;
    instr_valid = 1'b0;
    @(negedge clk);
    chk_outs(E_MRD, "rst_ld_pending");
    #1;
    reset = 1'b1;
    #1;
    chk_outs(E_NONE, "rst_ld_drop");
    chk_ret(0, "rst_ld_drop");
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(NOP, 0, 0, 0, E_NONE, 0, "post_reset_idle");
    step(ADD, 1, 0, 0, E_FETCH, 0, "post_reset_fetch");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
